// File: rtl/mem_dcache_ctrl_pkg.sv
// rtl/mem_dcache_ctrl_pkg.sv - shared widths, access-size encodings and FSM states for the MEM-stage DCache sequencer
package mem_dcache_ctrl_pkg;

   // Default datapath width for the sequencer and its load formatter.
   localparam int DEF_WORD = 32;

   // mem_size encodings; 2'd3 is reserved and handled as a word access.
   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_CANCEL = 3'd4
   } state_t;

   // Byte enables for a store of the given size at byte offset a.
   function automatic logic [3:0] size_strb(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] strb;
      case (size)
         MEM_B:   strb = 4'b0001 << a;
         MEM_H:   strb = 4'b0011 << {a[1], 1'b0};
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/mem_dcache_ctrl_load_align.sv
// rtl/mem_dcache_ctrl_load_align.sv - combinational lane select and sign/zero extension of DCache read data
module mem_dcache_ctrl_load_align #(
   parameter int WORD = 32
) (
   input  logic [WORD-1:0] rdata,
   input  logic [1:0]      a,
   input  logic [1:0]      size,
   input  logic            uns,
   output logic [WORD-1:0] data
);
   import mem_dcache_ctrl_pkg::*;

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed byte/half lane, then extend it to a full word.
   always_comb begin
      lane_b = rdata[{a, 3'b000} +: 8];
      lane_h = a[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         MEM_B:   data = {{(WORD-8){~uns & lane_b[7]}}, lane_b};
         MEM_H:   data = {{(WORD-16){~uns & lane_h[15]}}, lane_h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_dcache_ctrl.sv
// rtl/mem_dcache_ctrl.sv - MEM-stage DCache request/response sequencer; optional MEM_MISALIGN_EXC_EN raises ale on misaligned half/word
module mem_dcache_ctrl #(
   parameter int WORD = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_valid,
   input  logic            mem_we,
   input  logic [1:0]      mem_size,
   input  logic            mem_unsigned,
   input  logic [WORD-1:0] mem_addr,
   input  logic [WORD-1:0] mem_wdata,
   input  logic            flush,
   output logic            d_req,
   output logic            d_we,
   output logic [WORD-1:0] d_addr,
   output logic [3:0]      d_wstrb,
   output logic [WORD-1:0] d_wdata,
   input  logic            d_addr_ok,
   input  logic            d_data_ok,
   input  logic [WORD-1:0] d_rdata,
   output logic [WORD-1:0] load_data,
   output logic            done,
   output logic            stall,
   output logic            ale
);
   import mem_dcache_ctrl_pkg::*;

   state_t          state, state_nxt;
   logic [WORD-1:0] addr_q, wdata_q, load_q, fmt_data;
   logic [1:0]      size_q;
   logic            we_q, uns_q;
   logic            latch, load_en, misalign;

`ifdef MEM_MISALIGN_EXC_EN
   logic ale_q;
   assign misalign = ((mem_size == MEM_H) & mem_addr[0]) |
                     ((mem_size[1] == 1'b1) & (mem_addr[1:0] != 2'b00));
   assign ale      = ale_q;

   // The exception flag is decided when the op is accepted and held until the next one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       ale_q <= 1'b0;
      else if (latch) ale_q <= misalign;
   end
`else
   assign misalign = 1'b0;
   assign ale      = 1'b0;
`endif

   mem_dcache_ctrl_load_align #(.WORD(WORD)) u_load_align (
      .rdata (d_rdata),
      .a     (addr_q[1:0]),
      .size  (size_q),
      .uns   (uns_q),
      .data  (fmt_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Operation fields are captured once so the request stays stable until accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= MEM_B;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
      end else if (latch) begin
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         size_q  <= mem_size;
         we_q    <= mem_we;
         uns_q   <= mem_unsigned;
      end
   end

   // Formatted load data is registered on the response so it is valid during DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         load_q <= '0;
      else if (load_en) load_q <= fmt_data;
   end

   // Next-state: flush wins in REQ; a flush after acceptance must still swallow the response.
   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      load_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_valid && !flush) begin
               latch     = 1'b1;
               state_nxt = misalign ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush) begin
               state_nxt = ST_IDLE;
            end else if (d_addr_ok && d_data_ok) begin
               load_en   = 1'b1;
               state_nxt = ST_DONE;
            end else if (d_addr_ok) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (d_data_ok) begin
               load_en   = 1'b1;
               state_nxt = ST_DONE;
            end else if (flush) begin
               state_nxt = ST_CANCEL;
            end
         end
         ST_CANCEL: begin
            if (d_data_ok) state_nxt = ST_IDLE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request fields; byte enables are only driven for a live store request.
   always_comb begin
      d_req   = (state == ST_REQ) && !flush;
      d_we    = we_q;
      d_addr  = {addr_q[WORD-1:2], 2'b00};
      d_wstrb = ((state == ST_REQ) && we_q) ? size_strb(size_q, addr_q[1:0]) : 4'b0000;
      case (size_q)
         MEM_B:   d_wdata = {4{wdata_q[7:0]}};
         MEM_H:   d_wdata = {2{wdata_q[15:0]}};
         default: d_wdata = wdata_q;
      endcase
   end

   assign load_data = load_q;
   assign done      = (state == ST_DONE);
   assign stall     = (mem_valid && (state != ST_DONE) && !flush) || (state == ST_CANCEL);

endmodule

// File: tb/tb_mem_dcache_ctrl.sv
// tb/tb_mem_dcache_ctrl.sv - table-driven scoreboard bench for mem_dcache_ctrl
module tb_mem_dcache_ctrl;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_load;
   } vec_t;

   localparam int NV = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_we, mem_unsigned, flush;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        d_req, d_we, d_addr_ok, d_data_ok;
   logic [31:0] d_addr, d_wdata, d_rdata, load_data;
   logic [3:0]  d_wstrb;
   logic        done, stall, ale;

   int          errors = 0;
   int          checks = 0;
   vec_t        vt [NV];
   vec_t        hv;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   mem_dcache_ctrl #(.WORD(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_valid    (mem_valid),
      .mem_we       (mem_we),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .flush        (flush),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wstrb      (d_wstrb),
      .d_wdata      (d_wdata),
      .d_addr_ok    (d_addr_ok),
      .d_data_ok    (d_data_ok),
      .d_rdata      (d_rdata),
      .load_data    (load_data),
      .done         (done),
      .stall        (stall),
      .ale          (ale)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_valid = 0; mem_we = 0; mem_size = 0; mem_unsigned = 0;
      mem_addr = 0; mem_wdata = 0; flush = 0;
      d_addr_ok = 0; d_data_ok = 0; d_rdata = 0;
   endtask

   // Cycle 0: present the op in IDLE; the expected load result joins the scoreboard.
   task automatic start_op(input vec_t v, input bit push);
      @(negedge clk);
      mem_valid = 1; mem_we = v.we; mem_size = v.size; mem_unsigned = v.uns;
      mem_addr = v.addr; mem_wdata = v.wdata; d_addr_ok = 0; d_data_ok = 0;
      if (push) exp_q.push_back(v.e_load);
      #1;
      chk("c0_stall", stall, 1);
      chk("c0_dreq", d_req, 0);
   endtask

   task automatic check_req(input vec_t v, input string tag);
      chk({tag, "_dreq"}, d_req, 1);
      chk({tag, "_addr"}, d_addr, v.e_addr);
      chk({tag, "_we"}, d_we, v.we);
      chk({tag, "_strb"}, d_wstrb, v.e_strb);
      if (v.we) chk({tag, "_wdata"}, d_wdata, v.e_wdata);
      chk({tag, "_stall"}, stall, 1);
   endtask

   // DONE cycle: done pulses, stall releases, load result comes off the scoreboard.
   task automatic finish_done(input vec_t v, input bit flush_in);
      @(negedge clk);
      d_addr_ok = 0; d_data_ok = 0; d_rdata = 32'h0BAD0BAD; flush = flush_in;
      #1;
      chk("done", done, 1);
      chk("done_stall", stall, 0);
      chk("done_ale", ale, 0);
      if (!v.we) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got empty scoreboard want entry");
         end else begin
            chk("load_data", load_data, exp_q.pop_front());
         end
      end
      @(negedge clk);
      flush = 0; mem_valid = 0;
      #1;
      chk("post_done", done, 0);
   endtask

   task automatic run_op(input vec_t v, input bit fast, input bit flush_at_done);
      start_op(v, !v.we);
      @(negedge clk);
      d_addr_ok = 1; d_data_ok = fast; d_rdata = v.rdata;
      #1;
      check_req(v, "req");
      if (!fast) begin
         @(negedge clk);
         d_addr_ok = 0; d_data_ok = 1;
         #1;
         chk("wait_stall", stall, 1);
         chk("wait_done", done, 0);
         chk("wait_dreq", d_req, 0);
      end
      finish_done(v, flush_at_done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        we size  uns addr          wdata         rdata         e_addr        strb     e_wdata       e_load
      vt[0] = '{1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0,        32'hDEADBEEF, 32'h00001000, 4'b0000, 32'h0,        32'hDEADBEEF};
      vt[1] = '{1'b0, 2'd0, 1'b0, 32'h00001003, 32'h0,        32'h80112233, 32'h00001000, 4'b0000, 32'h0,        32'hFFFFFF80};
      vt[2] = '{1'b0, 2'd0, 1'b1, 32'h00001003, 32'h0,        32'h80112233, 32'h00001000, 4'b0000, 32'h0,        32'h00000080};
      vt[3] = '{1'b1, 2'd1, 1'b0, 32'h00002002, 32'h0000ABCD, 32'h0,        32'h00002000, 4'b1100, 32'hABCDABCD, 32'h0};
      vt[4] = '{1'b1, 2'd0, 1'b0, 32'h00003001, 32'h1234565A, 32'h0,        32'h00003000, 4'b0010, 32'h5A5A5A5A, 32'h0};
      vt[5] = '{1'b0, 2'd1, 1'b0, 32'h00004000, 32'h0,        32'h12348765, 32'h00004000, 4'b0000, 32'h0,        32'hFFFF8765};
      vt[6] = '{1'b0, 2'd1, 1'b1, 32'h00004002, 32'h0,        32'hF00D1234, 32'h00004000, 4'b0000, 32'h0,        32'h0000F00D};
      vt[7] = '{1'b1, 2'd2, 1'b0, 32'h00005004, 32'hCAFEF00D, 32'h0,        32'h00005004, 4'b1111, 32'hCAFEF00D, 32'h0};
      vt[8] = '{1'b0, 2'd0, 1'b0, 32'h00006001, 32'h0,        32'h00007F00, 32'h00006000, 4'b0000, 32'h0,        32'h0000007F};
      vt[9] = '{1'b0, 2'd3, 1'b0, 32'h00007000, 32'h0,        32'h89ABCDEF, 32'h00007000, 4'b0000, 32'h0,        32'h89ABCDEF};

      idle_inputs();
      rst = 0;
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_dreq", d_req, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall, 0);
      chk("rst_load", load_data, 0);
      chk("rst_ale", ale, 0);
      chk("rst_strb", d_wstrb, 0);
      chk("rst_addr", d_addr, 0);
      rst = 1;

      for (int i = 0; i < NV; i++) run_op(vt[i], i[0], 1'b0);

      // d_addr_ok held off for 5 REQ cycles: request must not move.
      start_op(vt[3], 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         d_addr_ok = 0; d_data_ok = 0;
         #1;
         check_req(vt[3], "hold");
      end
      @(negedge clk);
      d_addr_ok = 1; d_data_ok = 1;
      #1;
      check_req(vt[3], "hold_acc");
      finish_done(vt[3], 1'b0);

      // Flush in WAIT, response 3 cycles later: swallowed, no done.
      hv = vt[0]; hv.addr = 32'h8000; hv.e_addr = 32'h8000;
      start_op(hv, 1'b0);
      @(negedge clk);
      d_addr_ok = 1; d_data_ok = 0; d_rdata = 32'h11111111;
      #1;
      chk("fw_dreq", d_req, 1);
      @(negedge clk);
      d_addr_ok = 0; flush = 1;
      #1;
      chk("fw_done", done, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         flush = 0; mem_valid = 0; d_data_ok = (k == 2);
         #1;
         chk("cancel_stall", stall, 1);
         chk("cancel_done", done, 0);
      end
      @(negedge clk);
      d_data_ok = 0;
      #1;
      chk("cancel_exit_stall", stall, 0);
      chk("cancel_exit_done", done, 0);
      run_op(vt[1], 1'b0, 1'b0);

      // Flush in REQ: d_req drops in the same cycle.
      start_op(vt[7], 1'b0);
      @(negedge clk);
      flush = 1; d_addr_ok = 0;
      #1;
      chk("fr_dreq", d_req, 0);
      chk("fr_done", done, 0);
      @(negedge clk);
      flush = 0; mem_valid = 0;
      #1;
      chk("fr_idle_stall", stall, 0);
      chk("fr_idle_dreq", d_req, 0);
      run_op(vt[2], 1'b1, 1'b0);

      // Flush during DONE does not suppress completion.
      run_op(vt[5], 1'b1, 1'b1);

      // Asynchronous reset in REQ.
      start_op(vt[6], 1'b0);
      @(negedge clk);
      #1;
      chk("mid_dreq_pre", d_req, 1);
      #2;
      rst = 0; mem_valid = 0;
      #1;
      chk("mid_rst_dreq", d_req, 0);
      chk("mid_rst_stall", stall, 0);
      @(negedge clk);
      rst = 1;
      run_op(vt[6], 1'b0, 1'b0);

`ifdef MEM_MISALIGN_EXC_EN
      hv = vt[0]; hv.addr = 32'h1002;
      start_op(hv, 1'b0);
      @(negedge clk);
      #1;
      chk("mis_dreq", d_req, 0);
      chk("mis_done", done, 1);
      chk("mis_ale", ale, 1);
      @(negedge clk);
      mem_valid = 0;
      #1;
      chk("mis_post_done", done, 0);
      chk("mis_post_dreq", d_req, 0);
`else
      hv = vt[5]; hv.addr = 32'h1003; hv.e_addr = 32'h1000;
      hv.rdata = 32'hBEEF0000; hv.e_load = 32'hFFFFBEEF;
      run_op(hv, 1'b0, 1'b0);
`endif
      run_op(vt[0], 1'b1, 1'b0);

      chk("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
